// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath width and sequencer state encodings.
package cpu_pkg;

    localparam int DATA_W = 10;

    // Encoding 2'd3 is unused; the sequencer treats it as a fault and returns to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = x - y - bin, with borrow-out.
module full_subtractor (
    output logic diff,
    output logic bout,
    input  logic x,
    input  logic y,
    input  logic bin
);

    // Borrow when y outranks x, or when x==y and a borrow is already pending.
    always_comb begin
        diff = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtract unit: diff = a - b - bin, one bit per clock, LSB first.
// Accept edge -> WIDTH shift cycles -> one DONE cycle; the done pulse and the
// new result appear together on the edge that leaves DONE.
module serial_subtractor
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   res_sh;
    logic               borrow;
    logic [CNT_W-1:0]   count;
    logic               a_msb;
    logic               b_msb;
    logic               bit_d;
    logic               bit_b;
    logic               accept;

    assign ready  = (state == ST_IDLE);
    assign accept = ready & start;

    // Single cell reused every shift cycle on the current operand LSBs.
    full_subtractor u_cell (
        .diff (bit_d),
        .bout (bit_b),
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (borrow)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state logic; any unused encoding falls back to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_SHIFT;
            ST_SHIFT: if (count == LAST_BIT) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Operand capture on accept, then one bit per cycle while shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            borrow <= 1'b0;
            count  <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= bin;
            count  <= '0;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
        end else if (state == ST_SHIFT) begin
            res_sh <= {bit_d, res_sh[WIDTH-1:1]};
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            borrow <= bit_b;
            count  <= count + CNT_W'(1);
        end
    end

    // Result registers load only when leaving DONE; done pulses on that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else begin
            done <= (state == ST_DONE);
            if (state == ST_DONE) begin
                diff <= res_sh;
                bout <= borrow;
                ovf  <= (a_msb != b_msb) && (res_sh[WIDTH-1] != a_msb);
                zero <= (res_sh == '0);
            end
        end
    end

endmodule
